serial_adder_hex: RTL
=====================

Name: serial_adder_hex

Overview:
- Multi-cycle, parametrised add/subtract unit that replaces the fixed 4-bit combinational ripple adder on the switch/HEX board top.
- Operands are captured on a start request and processed BITS_PER_CYCLE bits per clock, using one registered carry.
- The result is latched, flagged with a one-cycle done pulse and driven onto active-low seven-segment digits (result nibbles plus a carry digit).
- Sits between the switch-sampling logic and the HEX outputs.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, bits processed per clock; legal values 1, 2, 4; must divide WIDTH.
- NDIG (localparam), WIDTH/4 + 1, number of seven-segment digits: result nibbles plus one carry digit.

Ports:
- clk  in  1  system clock; all state rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract (a - b); captured with operands.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in for add; ignored when sub=1.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- sum  out  WIDTH  latched result.
- cout  out  1  carry out; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- seg  out  7*NDIG  active-low gfedcba digits.
  - seg[7*i+6:7*i] shows sum nibble i for i < WIDTH/4.
  - The top digit shows cout as 0 or 1.

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, every seg digit = "0" (7'h40). Internal shift/carry registers are cleared and the operation in flight is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at a posedge captures a, b and sub, then goes to RUN.
    - Captured B operand is b when sub=0 and ~b when sub=1.
    - Initial carry is cin when sub=0 and 1 when sub=1.
  - RUN: each posedge adds the low BITS_PER_CYCLE bits of the shifted operands with the running carry, shifts them into the result register from the MSB end, and decrements the beat counter. After N = WIDTH/BITS_PER_CYCLE beats, go to DONE.
  - DONE: occupies one cycle, then goes to IDLE. In this cycle done=1 and busy=0, and sum/cout/ovf/seg have updated.
- Latency: start accepted at edge k; busy=1 from edge k to edge k+N; done=1 for the cycle after edge k+N.
- Next accepted start: edge k+N+2 at the earliest.
- start while RUN or DONE is ignored and not queued. a, b, sub and cin may change freely after capture without affecting the result.
- Result outputs and seg hold their last value until the next DONE. They never show partial sums.
- Arithmetic is modulo 2^WIDTH.
- ovf is computed from the carries entering and leaving bit WIDTH-1 during the final beat.
- seg is a registered decode of the latched values.
- Digit encoding:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Test Plan:
- Reset mid-RUN: WIDTH=8, BPC=1, start with a=FF, b=01; assert rst_n=0 after 3 beats -> sum=00, busy=0, done=0, all seg=40 immediately. After release, no done pulse appears.
- Add: WIDTH=8, BPC=1, a=3C, b=A5, cin=0, start at edge k -> busy high for 8 cycles, done at cycle k+9. Result: sum=E1, cout=0, ovf=0, seg digit0=79, digit1=06, digit2=40.
- Signed overflow: a=7F, b=01, cin=0 -> sum=80, cout=0, ovf=1.
- Carry-in and carry-out: a=FF, b=00, cin=1 -> sum=00, cout=1, ovf=0, carry digit=79.
- Subtract with borrow: sub=1, a=10, b=20 -> sum=F0, cout=0, ovf=0. Also sub=1, a=20, b=10 -> sum=10, cout=1.
- Width/rate sweep: WIDTH=16, BPC=4, a=FFFF, b=0001 -> done 5 cycles after start, sum=0000, cout=1. A start pulsed during busy is ignored (no second done). Random operand sweep at BPC=1, 2, 4 matches a reference model.

Source files
------------

// File: rtl/serial_adder_hex.sv
// serial_adder_hex: multi-cycle add/subtract unit that processes BITS_PER_CYCLE
// bits per clock through one registered carry, then latches the result and
// drives active-low seven-segment digits (result nibbles plus a carry digit).
//
// Ports:
//   clk    - system clock, all state on posedge
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only while idle
//   sub    - 0 = a + b + cin, 1 = a - b
//   a, b   - operands, captured on an accepted start
//   cin    - carry-in for add, ignored for subtract
//   busy   - high while beats are being processed
//   done   - one-cycle pulse, results valid from this cycle
//   sum    - latched result (modulo 2^WIDTH)
//   cout   - carry out; for subtract 1 means no borrow
//   ovf    - signed overflow
//   seg    - active-low gfedcba digits, nibble i at seg[7*i+6:7*i], cout on top digit
module serial_adder_hex #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sub,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           sum,
    output logic                       cout,
    output logic                       ovf,
    output logic [7*(WIDTH/4+1)-1:0]   seg
);
    localparam int NDIG = WIDTH / 4 + 1;
    localparam int BPC  = BITS_PER_CYCLE;
    localparam int N    = WIDTH / BPC;
    localparam int CW   = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_res;
    logic                r_carry;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic                r_ovf;
    logic [7*NDIG-1:0]   r_seg;

    logic [BPC:0]        w_c;
    logic [BPC-1:0]      w_beat;
    logic [WIDTH+BPC-1:0] w_cat;
    logic [WIDTH-1:0]    w_next_res;
    logic [7*NDIG-1:0]   w_seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Ripple through the beat's bits; on the final beat w_c[BPC-1] is the carry
    // into the word MSB and w_c[BPC] the carry out of it.
    always_comb begin
        w_c    = '0;
        w_beat = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < BPC; i++) begin
            w_beat[i] = r_a[i] ^ r_b[i] ^ w_c[i];
            w_c[i+1]  = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    end

    // Beat bits enter the result from the MSB end, so after N beats the word is aligned.
    assign w_cat      = {w_beat, r_res} >> BPC;
    assign w_next_res = w_cat[WIDTH-1:0];

    always_comb begin
        w_seg = '0;
        for (int i = 0; i < NDIG - 1; i++)
            w_seg[7*i +: 7] = hex7(w_next_res[4*i +: 4]);
        w_seg[7*(NDIG-1) +: 7] = w_c[BPC] ? 7'h79 : 7'h40;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_seg   <= {NDIG{7'h40}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= sub ? ~b : b;
                    r_carry <= sub | cin;
                    r_cnt   <= CW'(N - 1);
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_a     <= r_a >> BPC;
                    r_b     <= r_b >> BPC;
                    r_carry <= w_c[BPC];
                    r_res   <= w_next_res;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_next_res;
                        r_cout  <= w_c[BPC];
                        r_ovf   <= w_c[BPC] ^ w_c[BPC-1];
                        r_seg   <= w_seg;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign seg  = r_seg;
endmodule
